// File: rtl/lilme_gemm_if.sv
// Host bus for lilme_gemm: opcode/data in, address/data/strobes out.
interface lilme_gemm_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [2:0]    ME_opcode;
  logic [DW-1:0] Data_in;
  logic          in_valid;
  logic [AW-1:0] Address_out;
  logic          Busy;
  logic [DW-1:0] Data_out;
  logic          out_valid;
  logic          done;

  modport master (
    output ME_opcode, Data_in, in_valid,
    input  Address_out, Busy, Data_out, out_valid, done
  );

  modport slave (
    input  ME_opcode, Data_in, in_valid,
    output Address_out, Busy, Data_out, out_valid, done
  );
endinterface

// File: rtl/lilme_gemm.sv
// Parametrised M x K by K x N matrix-multiply engine, one MAC per cycle.
// Optional accumulate opcode (C += A*B) is built only with `LILME_ACC_EN.
module lilme_gemm #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int M  = 4,
  parameter int K  = 4,
  parameter int N  = 4
) (
  input logic         clk,
  input logic         reset,
  lilme_gemm_if.slave bus
);
  localparam int unsigned NA  = M * K;
  localparam int unsigned NB  = K * N;
  localparam int unsigned NC  = M * N;
  localparam int unsigned AIW = (NA > 1) ? $clog2(NA) : 1;
  localparam int unsigned BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CIW = (NC > 1) ? $clog2(NC) : 1;
  localparam int unsigned MXN = (NA > NB) ? ((NA > NC) ? NA : NC) : ((NB > NC) ? NB : NC);
  localparam int unsigned IW  = $clog2(MXN + 1);
  localparam int unsigned MW  = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned KW  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned NW  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    OP_NOP       = 3'b000,
    OP_LOAD_ADDR = 3'b001,
    OP_LOAD_A    = 3'b010,
    OP_LOAD_B    = 3'b011,
    OP_CLEAR_C   = 3'b100,
    OP_MUL       = 3'b101,
    OP_MAC       = 3'b110,
    OP_READ_C    = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_READ
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]   a_mem [NA];
  logic [DW-1:0]   b_mem [NB];
  logic [DW-1:0]   c_mem [NC];
  logic [IW-1:0]   idx_q;
  logic [MW-1:0]   i_q;
  logic [KW-1:0]   k_q;
  logic [NW-1:0]   j_q;
  logic [AW-1:0]   base_q;
  logic [2*DW-1:0] acc_q;
  logic            done_q;
`ifdef LILME_ACC_EN
  logic            mac_q;
`endif

  logic [AIW-1:0]  a_idx;
  logic [BIW-1:0]  b_idx;
  logic [CIW-1:0]  c_idx;
  logic [2*DW-1:0] init_val;
  logic [2*DW-1:0] sum;
  logic            idx_last_a, idx_last_b, idx_last_c;
  logic            i_last, j_last, k_last;

  assign a_idx = AIW'(i_q) * AIW'(K) + AIW'(k_q);
  assign b_idx = BIW'(k_q) * BIW'(N) + BIW'(j_q);
  assign c_idx = CIW'(i_q) * CIW'(N) + CIW'(j_q);

  assign idx_last_a = (idx_q == IW'(NA - 1));
  assign idx_last_b = (idx_q == IW'(NB - 1));
  assign idx_last_c = (idx_q == IW'(NC - 1));
  assign i_last     = (i_q == MW'(M - 1));
  assign j_last     = (j_q == NW'(N - 1));
  assign k_last     = (k_q == KW'(K - 1));

`ifdef LILME_ACC_EN
  assign init_val = mac_q ? (2*DW)'(c_mem[c_idx]) : '0;
`else
  assign init_val = '0;
`endif

  assign sum = ((k_q == '0) ? init_val : acc_q)
             + (2*DW)'(a_mem[a_idx]) * (2*DW)'(b_mem[b_idx]);

  assign bus.Busy        = (state_q != S_IDLE);
  assign bus.out_valid   = (state_q == S_READ);
  assign bus.done        = done_q;
  assign bus.Data_out    = (state_q == S_READ) ? c_mem[CIW'(idx_q)] : '0;
  assign bus.Address_out = (state_q == S_LOAD_A || state_q == S_LOAD_B || state_q == S_READ)
                         ? base_q + AW'(idx_q) : base_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        case (bus.ME_opcode)
          OP_LOAD_A: state_d = S_LOAD_A;
          OP_LOAD_B: state_d = S_LOAD_B;
          OP_MUL:    state_d = S_COMPUTE;
`ifdef LILME_ACC_EN
          OP_MAC:    state_d = S_COMPUTE;
`endif
          OP_READ_C: state_d = S_READ;
          default:   state_d = S_IDLE;
        endcase
      end
      S_LOAD_A:  if (bus.in_valid && idx_last_a) state_d = S_IDLE;
      S_LOAD_B:  if (bus.in_valid && idx_last_b) state_d = S_IDLE;
      S_COMPUTE: if (i_last && j_last && k_last) state_d = S_IDLE;
      S_READ:    if (idx_last_c) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand stores have no reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_A && bus.in_valid) a_mem[AIW'(idx_q)] <= bus.Data_in;
    if (state_q == S_LOAD_B && bus.in_valid) b_mem[BIW'(idx_q)] <= bus.Data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      base_q <= '0;
      acc_q  <= '0;
      done_q <= 1'b0;
`ifdef LILME_ACC_EN
      mac_q  <= 1'b0;
`endif
      for (int unsigned n = 0; n < NC; n++) c_mem[n] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          case (bus.ME_opcode)
            OP_LOAD_ADDR: base_q <= AW'(bus.Data_in);
            OP_CLEAR_C:   for (int unsigned n = 0; n < NC; n++) c_mem[n] <= '0;
`ifdef LILME_ACC_EN
            OP_MUL:       mac_q <= 1'b0;
            OP_MAC:       mac_q <= 1'b1;
`endif
            default: ;
          endcase
        end
        S_LOAD_A: if (bus.in_valid) idx_q <= idx_last_a ? '0 : idx_q + 1'b1;
        S_LOAD_B: if (bus.in_valid) idx_q <= idx_last_b ? '0 : idx_q + 1'b1;
        S_COMPUTE: begin
          acc_q <= sum;
          if (k_last) begin
            c_mem[c_idx] <= sum[DW-1:0];
            k_q <= '0;
            if (j_last) begin
              j_q <= '0;
              if (i_last) begin
                i_q    <= '0;
                done_q <= 1'b1;
              end else begin
                i_q <= i_q + 1'b1;
              end
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_READ: begin
          if (idx_last_c) begin
            idx_q  <= '0;
            done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lilme_gemm.sv
// Self-checking bench for lilme_gemm against a plain-arithmetic matrix model.
module tb_lilme_gemm;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lilme_gemm_if #(.DW(DW), .AW(AW)) bif ();
    lilme_gemm #(.DW(DW), .AW(AW), .M(4), .K(4), .N(4)) dut (
        .clk(clk), .reset(reset), .bus(bif)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    longint unsigned ra[16];
    longint unsigned rb[16];
    longint unsigned rc[16];
    logic [31:0] base_m;
    logic [31:0] got[16];
    logic [31:0] mat_a[16];
    logic [31:0] mat_b[16];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] din);
        bif.ME_opcode = op;
        bif.Data_in   = din;
        step();
        bif.ME_opcode = 3'b000;
    endtask

    task automatic model_mul(input bit acc);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                longint unsigned s;
                s = acc ? rc[i*4+j] : 64'd0;
                for (int k = 0; k < 4; k++) s += ra[i*4+k] * rb[k*4+j];
                rc[i*4+j] = s & 64'hFFFF_FFFF;
            end
    endtask

    task automatic load(input logic [2:0] op, input logic [31:0] d[16],
                        input int stall_at, input int stall_len);
        issue(op, 32'h0);
        check("load_busy", bif.Busy, 1);
        for (int n = 0; n < 16; n++) begin
            if (n == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bif.in_valid = 1'b0;
                    bif.Data_in  = $urandom;
                    check("stall_addr", bif.Address_out, base_m + 32'(n));
                    step();
                end
            end
            bif.Data_in  = d[n];
            bif.in_valid = 1'b1;
            check("load_addr", bif.Address_out, base_m + 32'(n));
            step();
            if (op == 3'b010) ra[n] = d[n]; else rb[n] = d[n];
        end
        bif.in_valid = 1'b0;
        check("load_busy_fall", bif.Busy, 0);
    endtask

    task automatic read_c();
        issue(3'b111, 32'h0);
        for (int n = 0; n < 16; n++) begin
            check("rd_valid", bif.out_valid, 1);
            check("rd_addr", bif.Address_out, base_m + 32'(n));
            check("rd_data", bif.Data_out, rc[n]);
            got[n] = bif.Data_out;
            step();
        end
        check("rd_done", bif.done, 1);
        check("rd_busy", bif.Busy, 0);
        check("rd_valid_fall", bif.out_valid, 0);
    endtask

    task automatic compute(input logic [2:0] op, input int inj_cycle, input int rst_cycle);
        int cnt;
        bit aborted;
        cnt = 0;
        aborted = 0;
        issue(op, 32'h0);
        while (bif.Busy && cnt < 200) begin
            cnt++;
            bif.ME_opcode = (cnt == inj_cycle) ? 3'b111 : 3'b000;
            if (cnt == rst_cycle) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                aborted = 1;
                break;
            end
            step();
        end
        bif.ME_opcode = 3'b000;
        if (aborted) begin
            check("rst_busy", bif.Busy, 0);
            check("rst_done", bif.done, 0);
            foreach (rc[n]) rc[n] = 0;
            base_m = 32'h0;
        end else begin
            check("cmp_cycles", cnt, 64);
            check("cmp_done", bif.done, 1);
            model_mul(op == 3'b110);
        end
    endtask

    initial begin
        bif.ME_opcode = 3'b000;
        bif.Data_in   = '0;
        bif.in_valid  = 1'b0;
        base_m = 32'h0;
        foreach (rc[n]) rc[n] = 0;
        step();
        step();
        check("rst_busy0", bif.Busy, 0);
        check("rst_valid0", bif.out_valid, 0);
        check("rst_done0", bif.done, 0);
        check("rst_data0", bif.Data_out, 0);
        check("rst_addr0", bif.Address_out, 0);
        reset = 1'b0;

        issue(3'b001, 32'h100);
        base_m = 32'h100;
        check("ldaddr_busy", bif.Busy, 0);
        check("ldaddr_addr", bif.Address_out, 32'h100);
        read_c();

        for (int n = 0; n < 16; n++) begin
            mat_a[n] = 32'(n);
            mat_b[n] = 32'(n + 1);
        end
        load(3'b010, mat_a, 7, 3);
        load(3'b011, mat_b, $urandom_range(15), $urandom_range(2));
        compute(3'b101, 10, 0);
        read_c();
        check("c00_mul", got[0], 62);
        check("c33_mul", got[15], 560);

`ifdef LILME_ACC_EN
        compute(3'b110, 0, 0);
        read_c();
        check("c00_mac", got[0], 124);
        check("c33_mac", got[15], 1120);
`else
        issue(3'b110, 32'h0);
        check("mac_ignored", bif.Busy, 0);
        step();
        check("mac_ignored2", bif.Busy, 0);
        read_c();
`endif

        compute(3'b101, 0, 20);
        read_c();
        compute(3'b101, 0, 0);
        read_c();
        check("c00_after_rst", got[0], 62);

        issue(3'b100, 32'h0);
        check("clr_busy", bif.Busy, 0);
        foreach (rc[n]) rc[n] = 0;
        read_c();

        for (int it = 0; it < 3; it++) begin
            base_m = $urandom;
            issue(3'b001, base_m);
            for (int n = 0; n < 16; n++) begin
                mat_a[n] = $urandom;
                mat_b[n] = (it == 0) ? 32'hFFFF_FFFF : $urandom;
            end
            load(3'b010, mat_a, $urandom_range(15), $urandom_range(3));
            load(3'b011, mat_b, $urandom_range(15), $urandom_range(3));
            compute(3'b101, $urandom_range(1, 60), 0);
            read_c();
`ifdef LILME_ACC_EN
            compute(3'b110, 0, 0);
            read_c();
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lilme_gemm.md
# lilme_gemm

Parametrised matrix-multiply engine, successor to the fixed 4×4 LilME. Holds operand matrices A (M×K) and B (K×N) and result C (M×N) in internal register arrays. Executes C = A·B, or optionally C += A·B, with one multiply-accumulate per cycle. Sits on the same opcode-driven host bus as LilME and adds explicit valid/done strobes and an external word address.

## Interface
- `DW`, 32: element width in bits (A, B, Data_in, Data_out).
- `AW`, 32: address width.
- `M`, 4: rows of A and C.
- `K`, 4: columns of A, rows of B (inner dimension).
- `N`, 4: columns of B and C.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ME_opcode` in 3: command, sampled only in IDLE.
- `Data_in` in DW: load data; also the base address for LOAD_ADDR (low AW bits).
- `in_valid` in 1: Data_in holds a valid load word.
- `Address_out` out AW: base + current element index during LOAD_A, LOAD_B and READ; otherwise base.
- `Busy` out 1: high whenever the state is not IDLE.
- `Data_out` out DW: C element being read.
- `out_valid` out 1: Data_out is valid this cycle.
- `done` out 1: one-cycle pulse when a COMPUTE or READ finishes.

## Operation
- Opcodes:
  - 000 IDLE/NOP.
  - 001 LOAD_ADDR: base ← Data_in[AW-1:0]; completes in one cycle; Busy stays 0.
  - 010 LOAD_A.
  - 011 LOAD_B.
  - 100 CLEAR_C: all C ← 0 in one cycle; Busy stays 0.
  - 101 MUL: C = A·B.
  - 110 MAC: C += A·B, only with the macro (see Configuration).
  - 111 READ_C.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, READ.
- Opcodes arriving while Busy=1 are ignored. Undefined opcodes are ignored.
- LOAD_A:
  - Accepts M·K words in row-major order, one per cycle where in_valid=1. Stalls while in_valid=0.
  - The index increments on each accepted word.
  - After the last word is accepted, returns to IDLE.
- LOAD_B: same as LOAD_A, with K·N words.
- COMPUTE:
  - Counters i (0..M-1), j (0..N-1), k (0..K-1), with k innermost, then j, then i.
  - Each cycle: acc ← (k==0 ? init : acc) + A[i][k]·B[k][j].
  - init = 0 for MUL; init = C[i][j] for MAC.
  - At k==K-1 the sum is written to C[i][j].
- Arithmetic:
  - Unsigned.
  - Products and acc are 2·DW bits.
  - The C store is DW bits, keeping the low DW bits (modulo 2^DW, no saturation).
- READ: emits C in row-major order, M·N words on consecutive cycles. There is no back-pressure.
- Reset:
  - State ← IDLE; counters, base, acc and C ← 0.
  - A and B contents are not cleared.
  - Reset during any operation aborts it. A following load restarts at index 0; partially loaded elements retain their new values.

## Timing
- Reset values: Busy=0, out_valid=0, done=0, Data_out=0, Address_out=0.
- An opcode is sampled on the rising edge with state IDLE. For 010, 011, 101, 110 and 111, Busy=1 from the next cycle.
- LOAD: the word is captured on an edge where in_valid=1. Address_out = base+index is registered and advances the cycle after each accept. Busy falls the cycle after the last accept.
- COMPUTE: exactly M·N·K cycles in COMPUTE. done=1 and Busy=0 in the following cycle. The default size takes 64 cycles.
- READ: out_valid=1 for M·N cycles starting the cycle after the opcode is sampled, with Address_out = base+index aligned to Data_out. done pulses in the cycle after the last word, together with Busy=0.
- A new opcode may be accepted in the same cycle that Busy returns to 0.

## Configuration
- `LILME_ACC_EN`
  - Defined: opcode 110 (MAC) runs COMPUTE with init = C[i][j], adding onto the existing C.
  - Undefined: 110 is an undefined opcode and is ignored (stays IDLE, Busy=0). The C-read path in COMPUTE is not built.

## Test plan
- Reset, then LOAD_ADDR with Data_in=0x100 -> Busy stays 0; a following READ_C shows Address_out 0x100..0x10F and Data_out=0 for all 16 words.
- LOAD_A with 0..15, with in_valid deasserted for 3 cycles mid-stream -> the load stalls without skipping; Busy falls the cycle after the 16th accept.
- LOAD_B with 1..16, then MUL -> Busy high for 64 cycles, then done pulses. READ_C gives C[0][0]=62 and C[3][3]=560.
- Issue 111 at cycle 10 of MUL -> it is ignored; MUL results are unchanged.
- With `LILME_ACC_EN`, MAC after the MUL above -> C[0][0]=124 and C[3][3]=1120. Without the macro, 110 leaves Busy=0 and C unchanged.
- Assert reset at cycle 20 of MUL -> next cycle Busy=0 and all C read back 0. A new MUL then yields C[0][0]=62.
